// File: rtl/program_sequencer.sv
// Program counter with a hardware return-address stack.
// One action per edge, chosen by priority: reset > stall > ret > call > jump > branch > increment.
module program_sequencer #(
  parameter int unsigned            ADDR_W       = 16,
  parameter int unsigned            OFF_W        = 8,
  parameter int unsigned            STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]      RESET_VECTOR = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               increment,
  input  logic                               jump_set,
  input  logic [ADDR_W-1:0]                  jumpcount,
  input  logic                               branch_taken,
  input  logic [OFF_W-1:0]                   branch_offset,
  input  logic                               call,
  input  logic                               ret,
  output logic [ADDR_W-1:0]                  count,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);

  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_RET_ERR,
    ACT_CALL,
    ACT_CALL_ERR,
    ACT_JUMP,
    ACT_BRANCH,
    ACT_INC
  } action_e;

  action_e           act;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic              push_en;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] off_ext;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              full, empty;

  // Storage is deliberately unreset; entries at or above the level are never read.
  logic [ADDR_W-1:0] stack_q [0:STACK_DEPTH-1];

  assign full     = (level_q == LVL_W'(STACK_DEPTH));
  assign empty    = (level_q == '0);
  assign wr_idx   = level_q[IDX_W-1:0];
  assign rd_idx   = IDX_W'(level_q - LVL_W'(1));
  assign ret_addr = count_q + ADDR_W'(1);
  assign off_ext  = ADDR_W'($signed(branch_offset));

  always_comb begin
    act = ACT_HOLD;
    if (stall) begin
      act = ACT_HOLD;
    end else if (ret) begin
      act = empty ? ACT_RET_ERR : ACT_RET;
    end else if (call) begin
      act = full ? ACT_CALL_ERR : ACT_CALL;
    end else if (jump_set) begin
      act = ACT_JUMP;
    end else if (branch_taken) begin
      act = ACT_BRANCH;
    end else if (increment) begin
      act = ACT_INC;
    end
  end

  always_comb begin
    count_d = count_q;
    level_d = level_q;
    err_d   = err_q;
    push_en = 1'b0;
    unique case (act)
      ACT_RET: begin
        count_d = stack_q[rd_idx];
        level_d = level_q - LVL_W'(1);
      end
      ACT_CALL: begin
        push_en = 1'b1;
        count_d = jumpcount;
        level_d = level_q + LVL_W'(1);
      end
      ACT_RET_ERR,
      ACT_CALL_ERR: err_d   = 1'b1;
      ACT_JUMP:     count_d = jumpcount;
      ACT_BRANCH:   count_d = count_q + off_ext;
      ACT_INC:      count_d = count_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VECTOR;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_en) begin
      stack_q[wr_idx] <= ret_addr;
    end
  end

  assign count       = count_q;
  assign stack_level = level_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Table-driven bench for program_sequencer (STACK_DEPTH=4) with a scoreboard queue of expected states.
module tb_program_sequencer;

  localparam int AW = 16;
  localparam int OW = 8;
  localparam int SD = 4;
  localparam int LW = $clog2(SD + 1);

  logic          clock = 1'b0;
  logic          reset, stall, increment, jump_set, branch_taken, call, ret;
  logic [AW-1:0] jumpcount;
  logic [OW-1:0] branch_offset;
  logic [AW-1:0] count;
  logic [LW-1:0] stack_level;
  logic          stack_full, stack_empty, stack_err;

  int checks   = 0;
  int failures = 0;

  program_sequencer #(
    .ADDR_W      (AW),
    .OFF_W       (OW),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .increment    (increment),
    .jump_set     (jump_set),
    .jumpcount    (jumpcount),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .call         (call),
    .ret          (ret),
    .count        (count),
    .stack_level  (stack_level),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_err    (stack_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         nm;
    logic          rst, stl, inc, jmp;
    logic [AW-1:0] jc;
    logic          br;
    logic [OW-1:0] off;
    logic          cl, rt;
    logic [AW-1:0] e_cnt;
    logic [LW-1:0] e_lvl;
    logic          e_err;
  } vec_t;

  typedef struct {
    string         nm;
    logic [AW-1:0] cnt;
    logic [LW-1:0] lvl;
    logic          err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input string nm, input logic rst, input logic stl, input logic inc,
                     input logic jmp, input logic [AW-1:0] jc, input logic br,
                     input logic [OW-1:0] off, input logic cl, input logic rt,
                     input logic [AW-1:0] e_cnt, input logic [LW-1:0] e_lvl, input logic e_err);
    vec_t v;
    v.nm = nm; v.rst = rst; v.stl = stl; v.inc = inc; v.jmp = jmp; v.jc = jc;
    v.br = br; v.off = off; v.cl = cl; v.rt = rt;
    v.e_cnt = e_cnt; v.e_lvl = e_lvl; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".count"}, 32'(count), 32'(e.cnt));
      chk({e.nm, ".level"}, 32'(stack_level), 32'(e.lvl));
      chk({e.nm, ".err"},   32'(stack_err), 32'(e.err));
      chk({e.nm, ".full"},  32'(stack_full), 32'(e.lvl == LW'(SD)));
      chk({e.nm, ".empty"}, 32'(stack_empty), 32'(e.lvl == '0));
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clock);
    reset = v.rst; stall = v.stl; increment = v.inc; jump_set = v.jmp; jumpcount = v.jc;
    branch_taken = v.br; branch_offset = v.off; call = v.cl; ret = v.rt;
    e.nm = v.nm; e.cnt = v.e_cnt; e.lvl = v.e_lvl; e.err = v.e_err;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; increment = 1'b0; jump_set = 1'b0; jumpcount = '0;
    branch_taken = 1'b0; branch_offset = '0; call = 1'b0; ret = 1'b0;

    //   name       rst stl inc jmp jc        br off    cl rt  count     lvl err
    add("rst0",     1, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 0, 0);
    add("inc1",     0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0001, 0, 0);
    add("inc2",     0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0002, 0, 0);
    add("inc3",     0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0003, 0, 0);
    add("jmp1000",  0, 0, 0, 1, 16'h1000, 0, 8'h00, 0, 0, 16'h1000, 0, 0);
    add("jmp0010",  0, 0, 0, 1, 16'h0010, 0, 8'h00, 0, 0, 16'h0010, 0, 0);
    add("brm16",    0, 0, 0, 0, 16'h0000, 1, 8'hF0, 0, 0, 16'h0000, 0, 0);
    add("brm1",     0, 0, 0, 0, 16'h0000, 1, 8'hFF, 0, 0, 16'hFFFF, 0, 0);
    add("incwrap",  0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 0, 0);
    add("brp127",   0, 0, 0, 0, 16'h0000, 1, 8'h7F, 0, 0, 16'h007F, 0, 0);
    add("hold",     0, 0, 0, 0, 16'h5555, 0, 8'h11, 0, 0, 16'h007F, 0, 0);
    add("jmp0100",  0, 0, 0, 1, 16'h0100, 0, 8'h00, 0, 0, 16'h0100, 0, 0);
    add("call2000", 0, 0, 0, 0, 16'h2000, 0, 8'h00, 1, 0, 16'h2000, 1, 0);
    add("call3000", 0, 0, 0, 0, 16'h3000, 0, 8'h00, 1, 0, 16'h3000, 2, 0);
    add("ret1",     0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h2001, 1, 0);
    add("ret2",     0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0101, 0, 0);
    add("retempty", 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0101, 0, 1);
    add("rst1",     1, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 0, 0);
    add("callA",    0, 0, 0, 0, 16'h0010, 0, 8'h00, 1, 0, 16'h0010, 1, 0);
    add("callB",    0, 0, 0, 0, 16'h0020, 0, 8'h00, 1, 0, 16'h0020, 2, 0);
    add("callC",    0, 0, 0, 0, 16'h0030, 0, 8'h00, 1, 0, 16'h0030, 3, 0);
    add("callD",    0, 0, 0, 0, 16'h0040, 0, 8'h00, 1, 0, 16'h0040, 4, 0);
    add("callfull", 0, 0, 0, 0, 16'h0050, 0, 8'h00, 1, 0, 16'h0040, 4, 1);
    add("retsticky",0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0031, 3, 1);
    add("incsticky",0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0032, 3, 1);
    add("rst2",     1, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 0, 0);
    add("call500",  0, 0, 0, 0, 16'h0500, 0, 8'h00, 1, 0, 16'h0500, 1, 0);
    add("callret",  0, 0, 1, 0, 16'h0600, 0, 8'h00, 1, 1, 16'h0001, 0, 0);
    add("stallret", 0, 1, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0001, 0, 0);
    add("stallmix", 0, 1, 1, 1, 16'h0700, 1, 8'h05, 1, 0, 16'h0001, 0, 0);
    add("callL1",   0, 0, 0, 0, 16'h0010, 0, 8'h00, 1, 0, 16'h0010, 1, 0);
    add("callL2",   0, 0, 0, 0, 16'h0020, 0, 8'h00, 1, 0, 16'h0020, 2, 0);
    add("callL3",   0, 0, 0, 0, 16'h0030, 0, 8'h00, 1, 0, 16'h0030, 3, 0);
    add("rstjmp",   1, 0, 0, 1, 16'h7777, 0, 8'h00, 1, 0, 16'h0000, 0, 0);
    add("retafter", 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 0, 1);
    add("callpri",  0, 0, 0, 1, 16'h0200, 0, 8'h00, 1, 0, 16'h0200, 1, 1);
    add("jmppri",   0, 0, 1, 1, 16'h0FFF, 1, 8'h40, 0, 0, 16'h0FFF, 1, 1);
    add("brpri",    0, 0, 1, 0, 16'h0000, 1, 8'h02, 0, 0, 16'h1001, 1, 1);

    foreach (vecs[i]) drive(vecs[i]);

    // Input changes must not reach count before the next rising edge.
    begin
      exp_t e;
      @(negedge clock);
      reset = 1'b0; stall = 1'b0; increment = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
      jump_set = 1'b1; jumpcount = 16'hABCD;
      #1;
      chk("noflow.count", 32'(count), 32'h1001);
      e.nm = "jmpABCD"; e.cnt = 16'hABCD; e.lvl = LW'(1); e.err = 1'b1;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_out();
      @(negedge clock);
      jump_set = 1'b0; ret = 1'b1;
      e.nm = "retlast"; e.cnt = 16'h0001; e.lvl = '0; e.err = 1'b1;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_out();
      ret = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, giving the address width of the counter and all address ports.
REQ-002 The block SHALL take parameter OFF_W, default 8, giving the width of the signed relative-branch offset.
REQ-003 The block SHALL take parameter STACK_DEPTH, default 8, giving the number of return-address entries; legal range is 2..64.
REQ-004 The block SHALL take parameter RESET_VECTOR, default 0, ADDR_W bits, giving the address loaded on reset.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clock  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  freezes count and stack when high.
REQ-008 increment  input  1  advance count by one.
REQ-009 jump_set  input  1  absolute jump to jumpcount.
REQ-010 jumpcount  input  ADDR_W  absolute target for jump and call.
REQ-011 branch_taken  input  1  relative branch by branch_offset.
REQ-012 branch_offset  input  OFF_W  two's-complement offset.
REQ-013 call  input  1  push return address, jump to jumpcount.
REQ-014 ret  input  1  pop return address into count.
REQ-015 count  output  ADDR_W  current program address, registered.
REQ-016 stack_level  output  clog2(STACK_DEPTH+1)  number of valid stack entries, registered.
REQ-017 stack_full / stack_empty  output  1 each  level==STACK_DEPTH / level==0, combinational from stack_level.
REQ-018 stack_err  output  1  sticky error flag, registered.

Function
REQ-019 Exactly one action SHALL occur per rising edge, chosen by fixed priority: reset > stall > ret > call > jump_set > branch_taken > increment > hold.
REQ-020 Hold (no request asserted) SHALL leave count, stack and stack_err unchanged.
REQ-021 increment SHALL set count <= count+1 modulo 2^ADDR_W; all-ones wraps to 0 without flagging.
REQ-022 jump_set SHALL set count <= jumpcount.
REQ-023 branch_taken SHALL set count <= count + sign-extended branch_offset, modulo 2^ADDR_W, wrapping in both directions.
REQ-024 call with stack not full SHALL write (count+1) mod 2^ADDR_W to entry stack_level, increment stack_level, and set count <= jumpcount, all in the same edge.
REQ-025 ret with stack not empty SHALL set count <= entry (stack_level-1) and decrement stack_level in the same edge.
REQ-026 call with stack full SHALL leave count and stack unchanged and set stack_err.
REQ-027 ret with stack empty SHALL leave count and stack unchanged and set stack_err.
REQ-028 Simultaneous call and ret SHALL execute ret only; call SHALL be ignored with no error.
REQ-029 stall high SHALL suppress every request including erroneous ones; stack_err SHALL not change during stall.
REQ-030 All new values SHALL be visible on count and stack_level one clock after the requesting edge; no combinational input-to-output path SHALL exist except to stack_full/stack_empty via stack_level.
REQ-031 stack_err SHALL remain set until reset.
REQ-032 Stack entries at or above stack_level SHALL be don't-care and never observable on count.

Reset
REQ-033 On a rising edge with reset high, count SHALL become RESET_VECTOR, stack_level 0, stack_err 0, regardless of all other inputs.
REQ-034 Reset asserted mid-sequence (e.g. during nested calls) SHALL discard all stack contents; a following ret SHALL raise stack_err.
REQ-035 Stack storage SHALL not require reset.

Verification
REQ-036 Defaults, STACK_DEPTH=4: reset, then 3 cycles increment -> count 0,1,2,3; jump_set jumpcount=0x1000 -> count 0x1000.
REQ-037 count=0x0010, branch_taken offset=0xF0 (-16) -> count 0x0000; next offset=0xFF (-1) -> count 0xFFFF; increment -> count 0x0000.
REQ-038 count=0x0100, call to 0x2000, then 0x3000 -> level 2; ret -> count 0x2001, level 1; ret -> count 0x0101, level 0, stack_empty 1.
REQ-039 Five calls at STACK_DEPTH=4 -> fifth leaves count at fourth target, level 4, stack_full 1, stack_err 1; stack_err stays 1 through later legal ops.
REQ-040 Same edge call+ret+increment with level 1 -> ret wins, level 0, no error; stall high with ret at level 0 -> no change, stack_err 0.
REQ-041 Reset during level 3 with jump_set high -> count RESET_VECTOR, level 0, stack_err 0; subsequent ret -> stack_err 1, count unchanged.
